bram_burst_reader: RTL and testbench
====================================

Name: bram_burst_reader

Overview:
Read initiator for the single-port BRAM (addr/we/re, registered data_out, 1-cycle read latency). On a start command it issues sequential BRAM reads from a base address for a given word count. It absorbs the BRAM read latency and streams the words out on a valid/ready interface through a small credit-controlled skid FIFO. It feeds the SIMD lane datapath with vector operands.

Parameters:
DATA_WIDTH, 128, word width; equals BRAM DATA_WIDTH.
DEPTH, 256, BRAM depth in words; address width AW = $clog2(DEPTH).
FIFO_DEPTH, 2, output skid FIFO entries; minimum 2.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  command strobe; sampled only in IDLE.
base_addr  input  AW  first word address.
length  input  AW+1  word count, 0..DEPTH.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse at burst completion.
mem_addr  output  AW  BRAM address.
mem_re  output  1  BRAM read enable.
mem_we  output  1  BRAM write enable; constant 0.
mem_rdata  input  DATA_WIDTH  BRAM data_out.
m_valid  output  1  output word valid.
m_ready  input  1  downstream accept.
m_data  output  DATA_WIDTH  output word, FIFO head.
m_last  output  1  high with the final word of the burst.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; FIFO is emptied; in-flight flag is cleared.
  - busy, done, mem_re, m_valid and m_last are 0; mem_addr is 0.
  - Applies immediately, including mid-burst. Words not yet handed over are discarded and no done pulse is produced.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 with length>0 latches the address counter (=base_addr) and the remaining-issue counter (=length), then goes to READ.
  - IDLE: start=1 with length=0 goes directly to DONE; no reads are issued.
  - READ: the block issues while issue-credit is available and issues remain. Goes to DRAIN the cycle after the last read is issued.
  - DRAIN: waits until no read is in flight and the FIFO is empty, with the final handshake completed, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in READ and DRAIN; busy=0 in IDLE and DONE.
- start is ignored outside IDLE.
- Issue rule: mem_re=1 in READ when (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = m_valid & m_ready. mem_addr carries the current address counter in that cycle.
- On each issue:
  - address counter increments modulo DEPTH (wraps DEPTH-1 -> 0);
  - remaining-issue counter decrements;
  - inflight is set for the next cycle.
- mem_re is 0 whenever the block is not issuing. mem_addr then holds its last value.
- Capture: mem_rdata is written into the FIFO in the cycle after the issue cycle, when inflight=1. The FIFO never overflows; the bench asserts this.
- Latency, with start high in cycle 0:
  - first mem_re in cycle 1;
  - mem_rdata valid in cycle 2;
  - m_valid=1 in cycle 3.
- Throughput: with m_ready held high, one word per cycle is sustained after the first word.
- Backpressure: with m_ready=0, issue stops once the FIFO plus in-flight reach FIFO_DEPTH. m_data and m_last must stay stable while m_valid=1 and m_ready=0.
- m_last: a per-entry FIFO bit, set on the entry that holds the length-th word.
- A simultaneous FIFO push and pop keeps the count unchanged.

Decomposition:
- Package simd_mem_pkg:
  - state enum {IDLE, READ, DRAIN, DONE};
  - localparam defaults for DATA_WIDTH and DEPTH, shared with bram.
- One sub-module: sync_fifo, with DATA_WIDTH+1 bits (data plus last) and FIFO_DEPTH entries, using the same async active-low reset. It provides push, pop, count, full and empty.

Test Plan:
1. Preload mem[k]=k. Drive base=10, length=4, m_ready=1 -> mem_addr 10,11,12,13 in cycles 1-4; m_data 10..13 in cycles 3-6; m_last only on 13; done pulses in cycle 7; busy is high for cycles 1-6.
2. Same burst with m_ready toggled 1,0,0,1,... -> all 4 words are delivered in order; data is stable while stalled; FIFO never exceeds 2 entries; at most 2 reads outstanding.
3. Drive base=254, length=4 -> addresses 254,255,0,1; data mem[254],mem[255],mem[0],mem[1]; m_last on mem[1].
4. Drive length=0 -> mem_re never asserts; m_valid stays 0; done pulses in cycle 1; busy stays 0.
5. Drive length=256, base=0, m_ready=1 -> 256 words are delivered back-to-back; the address counter wraps to 0 at the end; exactly one done.
6. Pull rst_n low during cycle 4 of burst 1 -> outputs are 0 immediately and there is no done pulse. A second start issued while busy is ignored. A fresh start after reset works as in test 1.

Source files
------------

// File: rtl/simd_mem_pkg.sv
// Shared definitions for the SIMD memory-side blocks.
//   - DEFAULT_DATA_WIDTH / DEFAULT_DEPTH: BRAM geometry shared with the bram model.
//   - state_t: burst reader control states.
package simd_mem_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 128;
    localparam int unsigned DEFAULT_DEPTH      = 256;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with count/full/empty status.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  write strobe and data (ignored when full)
//   pop          read strobe (ignored when empty)
//   rdata        head entry (valid when !empty)
//   count        number of stored entries
//   full, empty  status flags
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read initiator for the single-port BRAM (1-cycle registered read latency).
// A start command issues sequential reads from base_addr for length words; returned
// words are captured into a skid FIFO and streamed out on a valid/ready interface.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               command strobe (sampled only in IDLE)
//   base_addr, length   first word address, word count (0..DEPTH)
//   busy, done          burst in progress, one-cycle completion pulse
//   mem_addr, mem_re    BRAM address and read enable
//   mem_we              BRAM write enable (always 0)
//   mem_rdata           BRAM read data
//   m_valid, m_ready    output handshake
//   m_data, m_last      output word and end-of-burst marker
module bram_burst_reader
    import simd_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] FIFO_LIMIT  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state_q;
    logic            busy_q, done_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   mem_addr_q;
    logic [AW:0]     remaining_q;
    logic            inflight_q;
    logic            inflight_last_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic [DATA_WIDTH:0] fifo_rdata;
    logic              pop, issue, drain_ok;
    logic [CW:0]       occupancy;
    logic [AW-1:0]     addr_next;

    // Credit check counts the word already in flight and frees the slot being popped now,
    // so the FIFO can never be overrun by a returning read.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue     = (state_q == READ) && (remaining_q != '0) && (occupancy < FIFO_LIMIT);
        addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
        // Burst is finished once nothing is in flight and this cycle's pop empties the FIFO.
        drain_ok  = !inflight_q &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            addr_q          <= '0;
            mem_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                inflight_last_q <= (remaining_q == (AW + 1)'(1));
                addr_q          <= addr_next;
                mem_addr_q      <= addr_q;
                remaining_q     <= remaining_q - (AW + 1)'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q      <= base_addr;
                            remaining_q <= length;
                            busy_q      <= 1'b1;
                            state_q     <= READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    if (issue && (remaining_q == (AW + 1)'(1))) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_ok) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Address is shown live while issuing, otherwise the last issued address is held.
    assign mem_addr = issue ? addr_q : mem_addr_q;
    assign mem_re   = issue;
    assign mem_we   = 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;

    assign pop     = m_valid && m_ready;
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_rdata[DATA_WIDTH-1:0];
    assign m_last  = fifo_rdata[DATA_WIDTH] && m_valid;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q && !fifo_full),
        .wdata ({inflight_last_q, mem_rdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bram_burst_reader.sv
module tb_bram_burst_reader;
    localparam int unsigned DW     = 128;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned FD     = 2;
    localparam int unsigned AW     = 8;
    localparam int          BIG    = 1000000;
    localparam int          BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_re, mem_we, m_valid, m_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    int t0 = 0;
    int rel;
    bit active = 1'b0;
    bit seen_done = 1'b0;
    int exp_done_rel = BIG;
    int first_re_rel, last_re_rel, first_valid_rel, done_rel, busy_cnt, done_cnt;
    int occ = 0;
    int          exp_addr[$];
    logic [DW:0] exp_word[$];
    logic [DW-1:0] dlog[$];
    logic [DW:0] w_exp;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    bram_burst_reader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;
    // BRAM model: registered read, one cycle latency.
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3 == 0);
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Compare process: every cycle the DUT is checked against the burst model.
    always @(negedge clk) begin
        if (rst_n && active) begin
            rel = cycle_no - t0;
            check("mem_we", mem_we, 0);
            check("done", done, rel == exp_done_rel);
            check("busy", busy, (rel >= 1) && (rel < exp_done_rel));
            if (busy) busy_cnt++;
            if (done) begin
                seen_done = 1'b1;
                done_rel  = rel;
                done_cnt++;
            end
            if (mem_re) begin
                if (first_re_rel < 0) first_re_rel = rel;
                last_re_rel = rel;
                occ++;
                if (exp_addr.size() == 0) check("extra_read", 1, 0);
                else check("mem_addr", mem_addr, exp_addr.pop_front());
            end
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (!m_valid) check("m_last_idle", m_last, 0);
            if (m_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (m_valid && m_ready) begin
                occ--;
                dlog.push_back(m_data);
                if (exp_word.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    w_exp = exp_word.pop_front();
                    check("m_data", m_data, w_exp[DW-1:0]);
                    check("m_last", m_last, w_exp[DW]);
                    if (exp_word.size() == 0) exp_done_rel = rel + 1;
                end
            end
            check("occupancy", (occ <= FD), 1);
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic start_burst(input int base, input int len, input int mode);
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back((base + i) % DEPTH);
            exp_word.push_back({1'(i == len - 1), mem[(base + i) % DEPTH]});
        end
        t0              = cycle_no;
        exp_done_rel    = (len == 0) ? 1 : BIG;
        seen_done       = 1'b0;
        first_re_rel    = -1;
        last_re_rel     = -1;
        first_valid_rel = -1;
        done_rel        = -1;
        busy_cnt        = 0;
        done_cnt        = 0;
        dlog.delete();
        active    = 1'b1;
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        m_ready   = ready_for(mode, 0);
    endtask

    task automatic finish_burst(input int mode, input bit restart);
        for (int c = 1; c <= BUDGET && !seen_done; c++) begin
            @(posedge clk);
            #1;
            start = restart && (c == 2);
            if (start) begin
                base_addr = AW'($urandom);
                length    = (AW + 1)'($urandom_range(1, DEPTH));
            end
            m_ready = ready_for(mode, c);
        end
        start = 1'b0;
        if (!seen_done) check("burst_timeout", 0, 1);
    endtask

    task automatic check_t1(input string tag);
        check({tag, "_first_re"}, first_re_rel, 1);
        check({tag, "_last_re"}, last_re_rel, 4);
        check({tag, "_first_valid"}, first_valid_rel, 3);
        check({tag, "_done_cycle"}, done_rel, 7);
        check({tag, "_busy_cycles"}, busy_cnt, 6);
        check({tag, "_words"}, dlog.size(), 4);
        for (int i = 0; i < 4; i++) check({tag, "_word"}, dlog[i], 10 + i);
    endtask

    initial begin
        for (int k = 0; k < int'(DEPTH); k++) mem[k] = DW'(k);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;

        // Basic burst, full throughput.
        start_burst(10, 4, 0);
        finish_burst(0, 1'b0);
        check_t1("t1");

        // Backpressure plus an ignored start while busy.
        start_burst(10, 4, 1);
        finish_burst(1, 1'b1);
        check("t2_words", dlog.size(), 4);
        for (int i = 0; i < 4; i++) check("t2_word", dlog[i], 10 + i);
        check("t2_done_count", done_cnt, 1);

        // Address wrap.
        start_burst(254, 4, 0);
        finish_burst(0, 1'b0);
        check("t3_words", dlog.size(), 4);
        check("t3_word0", dlog[0], 254);
        check("t3_word1", dlog[1], 255);
        check("t3_word2", dlog[2], 0);
        check("t3_word3", dlog[3], 1);

        // Zero-length command.
        start_burst(0, 0, 0);
        finish_burst(0, 1'b0);
        check("t4_no_read", first_re_rel, -1);
        check("t4_no_valid", first_valid_rel, -1);
        check("t4_done_cycle", done_rel, 1);
        check("t4_busy_cycles", busy_cnt, 0);

        // Full-depth burst streams back-to-back.
        start_burst(0, 256, 0);
        finish_burst(0, 1'b0);
        check("t5_words", dlog.size(), 256);
        check("t5_first_valid", first_valid_rel, 3);
        check("t5_done_cycle", done_rel, 259);
        check("t5_done_count", done_cnt, 1);

        // Reset in the middle of a burst.
        start_burst(10, 4, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        active = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_mem_re", mem_re, 0);
        check("t6_m_valid", m_valid, 0);
        check("t6_m_last", m_last, 0);
        check("t6_mem_addr", mem_addr, 0);
        exp_addr.delete();
        exp_word.delete();
        occ        = 0;
        stall_prev = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t6_rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t6_post_done", done, 0);
            check("t6_post_busy", busy, 0);
        end
        start_burst(10, 4, 0);
        finish_burst(0, 1'b0);
        check_t1("t6");

        // Randomized bursts, data and backpressure.
        for (int n = 0; n < 25; n++) begin
            int b;
            int l;
            for (int k = 0; k < int'(DEPTH); k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
            b = $urandom_range(0, DEPTH - 1);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 48);
            start_burst(b, l, 2);
            finish_burst(2, (l > 0) && ($urandom_range(0, 1) == 1));
            check("rnd_words", dlog.size(), l);
            check("rnd_done_count", done_cnt, 1);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
